// File: rtl/ram_line_interface.sv
// ----------------------------------------------------------------------------
// ram_line_interface
//
// Memory-interface stage that sits directly below the cache. A whole cache
// line is read or written with a single request pulse; the stage splits the
// line into WORDS_PER_LINE word beats on a narrow RAM bus, with a per-beat
// ready handshake, and returns a one-cycle completion pulse to the cache.
//
// Ports
//   CLK            : clock, all state updates on the rising edge
//   RESET          : synchronous, active-high; aborts any burst in flight
//   SIG_RAM_RD     : line read request pulse (only honoured while idle)
//   SIG_RAM_WR     : line write request pulse (only honoured while idle,
//                    wins over SIG_RAM_RD in the same cycle)
//   RAM_LINE_ADDR  : line address, captured with the request
//   MI_IN_DATA     : line to write, captured with SIG_RAM_WR
//   MI_OUT_DATA    : last completed read line (writes never change it)
//   MI_SIG_RAM_ACK : one-cycle completion pulse for reads and writes
//   BUS_ADDR       : word address {line, beat}
//   BUS_RE/BUS_WE  : word read / write strobes, held high across beats
//   BUS_WDATA      : write word for the current beat
//   BUS_RDATA      : read word, taken when BUS_READY=1 during a read beat
//   BUS_READY      : RAM completes the current beat this cycle
//   BUSY           : high whenever the stage is not idle
//
// All outputs are registers. The next value of every register is computed in
// a single combinational process and committed in a single clocked process.
// ----------------------------------------------------------------------------
module ram_line_interface #(
   parameter  int LINE_ADDR_SIZE = 12,
   parameter  int WORD_SIZE      = 32,
   parameter  int WORDS_PER_LINE = 4,
   localparam int LINE_SIZE      = WORD_SIZE * WORDS_PER_LINE,
   localparam int BEAT_W         = $clog2(WORDS_PER_LINE),
   localparam int BUS_ADDR_W     = LINE_ADDR_SIZE + BEAT_W
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      SIG_RAM_RD,
   input  logic                      SIG_RAM_WR,
   input  logic [LINE_ADDR_SIZE-1:0] RAM_LINE_ADDR,
   input  logic [LINE_SIZE-1:0]      MI_IN_DATA,
   output logic [LINE_SIZE-1:0]      MI_OUT_DATA,
   output logic                      MI_SIG_RAM_ACK,
   output logic [BUS_ADDR_W-1:0]     BUS_ADDR,
   output logic                      BUS_RE,
   output logic                      BUS_WE,
   output logic [WORD_SIZE-1:0]      BUS_WDATA,
   input  logic [WORD_SIZE-1:0]      BUS_RDATA,
   input  logic                      BUS_READY,
   output logic                      BUSY
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_BEAT = 2'd1,
      WR_BEAT = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Registered state
   state_t                    state_r;
   logic [BEAT_W-1:0]         beat_r;
   logic [LINE_ADDR_SIZE-1:0] line_addr_r;
   logic [LINE_SIZE-1:0]      wr_line_r;
   logic [LINE_SIZE-1:0]      rd_line_r;
   logic [LINE_SIZE-1:0]      out_data_r;
   logic                      ack_r;
   logic                      re_r;
   logic                      we_r;
   logic [BUS_ADDR_W-1:0]     bus_addr_r;
   logic [WORD_SIZE-1:0]      wdata_r;
   logic                      busy_r;

   // Next-state values
   state_t                    state_s;
   logic [BEAT_W-1:0]         beat_s;
   logic [BEAT_W-1:0]         next_beat_s;
   logic                      last_beat_s;
   logic [LINE_ADDR_SIZE-1:0] line_addr_s;
   logic [LINE_SIZE-1:0]      wr_line_s;
   logic [LINE_SIZE-1:0]      rd_line_s;
   logic [LINE_SIZE-1:0]      out_data_s;
   logic                      ack_s;
   logic                      re_s;
   logic                      we_s;
   logic [BUS_ADDR_W-1:0]     bus_addr_s;
   logic [WORD_SIZE-1:0]      wdata_s;
   logic                      busy_s;

   // Next-state and next-output logic of the burst FSM
   always_comb begin
      state_s     = state_r;
      beat_s      = beat_r;
      line_addr_s = line_addr_r;
      wr_line_s   = wr_line_r;
      rd_line_s   = rd_line_r;
      out_data_s  = out_data_r;
      ack_s       = 1'b0;
      re_s        = 1'b0;
      we_s        = 1'b0;
      bus_addr_s  = bus_addr_r;
      wdata_s     = wdata_r;
      next_beat_s = beat_r + BEAT_W'(1);
      last_beat_s = (beat_r == BEAT_W'(WORDS_PER_LINE - 1));

      case (state_r)
         IDLE: begin
            // Write has priority: the cache issues the write-back before the
            // refill, so a simultaneous read is simply dropped.
            if (SIG_RAM_WR) begin
               state_s     = WR_BEAT;
               beat_s      = '0;
               line_addr_s = RAM_LINE_ADDR;
               wr_line_s   = MI_IN_DATA;
               we_s        = 1'b1;
               bus_addr_s  = {RAM_LINE_ADDR, {BEAT_W{1'b0}}};
               wdata_s     = MI_IN_DATA[WORD_SIZE-1:0];
            end else if (SIG_RAM_RD) begin
               state_s     = RD_BEAT;
               beat_s      = '0;
               line_addr_s = RAM_LINE_ADDR;
               re_s        = 1'b1;
               bus_addr_s  = {RAM_LINE_ADDR, {BEAT_W{1'b0}}};
            end else begin
               state_s = IDLE;
            end
         end

         RD_BEAT: begin
            re_s = 1'b1;
            if (BUS_READY) begin
               rd_line_s[int'(beat_r)*WORD_SIZE +: WORD_SIZE] = BUS_RDATA;
               if (last_beat_s) begin
                  // Result becomes visible on the same edge that raises ACK
                  state_s    = DONE;
                  re_s       = 1'b0;
                  ack_s      = 1'b1;
                  beat_s     = '0;
                  out_data_s = rd_line_s;
               end else begin
                  beat_s     = next_beat_s;
                  bus_addr_s = {line_addr_r, next_beat_s};
               end
            end else begin
               beat_s = beat_r;
            end
         end

         WR_BEAT: begin
            we_s = 1'b1;
            if (BUS_READY) begin
               if (last_beat_s) begin
                  state_s = DONE;
                  we_s    = 1'b0;
                  ack_s   = 1'b1;
                  beat_s  = '0;
               end else begin
                  beat_s     = next_beat_s;
                  bus_addr_s = {line_addr_r, next_beat_s};
                  wdata_s    = wr_line_r[int'(next_beat_s)*WORD_SIZE +: WORD_SIZE];
               end
            end else begin
               beat_s = beat_r;
            end
         end

         DONE: begin
            state_s = IDLE;
         end

         default: begin
            state_s = IDLE;
            beat_s  = '0;
         end
      endcase

      busy_s = (state_s != IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r     <= IDLE;
         beat_r      <= '0;
         line_addr_r <= '0;
         wr_line_r   <= '0;
         rd_line_r   <= '0;
         out_data_r  <= '0;
         ack_r       <= 1'b0;
         re_r        <= 1'b0;
         we_r        <= 1'b0;
         bus_addr_r  <= '0;
         wdata_r     <= '0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         beat_r      <= beat_s;
         line_addr_r <= line_addr_s;
         wr_line_r   <= wr_line_s;
         rd_line_r   <= rd_line_s;
         out_data_r  <= out_data_s;
         ack_r       <= ack_s;
         re_r        <= re_s;
         we_r        <= we_s;
         bus_addr_r  <= bus_addr_s;
         wdata_r     <= wdata_s;
         busy_r      <= busy_s;
      end
   end

   assign MI_OUT_DATA    = out_data_r;
   assign MI_SIG_RAM_ACK = ack_r;
   assign BUS_ADDR       = bus_addr_r;
   assign BUS_RE         = re_r;
   assign BUS_WE         = we_r;
   assign BUS_WDATA      = wdata_r;
   assign BUSY           = busy_r;

endmodule
